wb_commit_trace: RTL and testbench
==================================

// Module: wb_commit_trace
// PURPOSE
//  Consumer of the MEM/WB pipeline-register outputs. Captures one commit record per retired
//  instruction (wb_have_inst=1): PC, rd write enable, rd index, write-back data, sequence number.
//  Records sit in a small FIFO and drain to a debug/trace port over a valid/ready handshake.
//  Never stalls the pipeline: when the FIFO is full, the record is dropped and counted.
// PARAMETERS
//  DEPTH  8                       FIFO entries; power of two, >=2
//  AW     $clog2(DEPTH)           pointer width (localparam, not overridable)
// PORTS
//  clk           in   1   core clock, single clock domain
//  reset         in   1   synchronous, active-low reset
//  wb_have_inst  in   1   WB stage holds a valid retiring instruction this cycle
//  wb_pc         in   32  PC of retiring instruction
//  wb_rf_WE      in   1   register-file write enable of retiring instruction
//  wb_rd         in   5   destination register index
//  wb_wdata      in   32  final write-back data (after WB mux)
//  trace_valid   out  1   head record available
//  trace_ready   in   1   sink accepts head record
//  trace_pc      out  32  head record PC
//  trace_we      out  1   head record write enable (0 when rd==x0)
//  trace_rd      out  5   head record rd
//  trace_wdata   out  32  head record data (0 when trace_we=0)
//  trace_seq     out  32  head record commit sequence number
//  trace_cycle   out  32  head record timestamp (0 without TRACE_TIMESTAMP_EN)
//  trace_ovf     out  1   sticky: at least one record dropped since reset
//  trace_drops   out  16  dropped-record count, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (reset=0 at posedge clk): rd/wr pointers, count, seq_ctr, cycle_ctr, drops, ovf -> 0;
//    all outputs read 0; trace_valid=0. Mid-drain reset discards all queued records.
//  - Commit: wb_have_inst=1 consumes sequence number seq_ctr; seq_ctr += 1 (wraps 2^32)
//    whether the record is stored or dropped, so gaps in trace_seq expose drops.
//  - Record formation: we = wb_rf_WE & (wb_rd!=0); wdata = we ? wb_wdata : 0; rd passed raw.
//  - Push accepted when count<DEPTH, or count==DEPTH and a pop occurs in the same cycle.
//    Otherwise drop: ovf<=1; drops<=drops+1 unless already 16'hFFFF.
//  - Pop when trace_valid & trace_ready. Outputs are registered from FIFO head; held stable
//    while trace_valid=1 and trace_ready=0.
//  - Latency: record committed in cycle N is visible at the trace port in cycle N+1 (empty FIFO,
//    no bypass). Throughput: 1 record/cycle sustained with trace_ready held at 1.
//  - Simultaneous push+pop: count unchanged; with count==1 the new record becomes head in N+1.
//  - Pointers wrap modulo DEPTH; full/empty decided from count (AW+1 bits), never ptr compare.
//  - trace_valid = (count!=0). When empty, trace_* payload holds its last value; sinks ignore it.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: 32-bit cycle_ctr increments every cycle out of reset
//    (wraps); its value in the commit cycle is stored with the record -> trace_cycle.
//  Not defined: no cycle_ctr, no storage for the field; trace_cycle tied to 32'b0.
// STRUCTURE
//  trace_defs.vh: record field widths (PC_W=32, RD_W=5, SEQ_W=32, TS_W=32), record packing
//    offsets, REC_W macro; shared with the testbench decoder.
//  Sub-module trace_sync_fifo (WIDTH=REC_W, DEPTH): sync FIFO, push/pop/count/head, sync reset.
//  Top level: record packing, seq/cycle/drop counters, ovf flag, push-accept logic.
// TESTING
//  1 Reset: hold reset=0 for 3 clks with wb_have_inst=1 -> trace_valid=0, drops=0, ovf=0, seq=0.
//  2 Single commit pc=0x80, WE=1, rd=5, wdata=0x1234, ready=1 -> next cycle valid=1,
//    pc=0x80, we=1, rd=5, wdata=0x1234, seq=0; valid drops the cycle after.
//  3 x0 write: WE=1, rd=0, wdata=0xDEAD -> trace_we=0, trace_wdata=0, rd=0.
//  4 Backpressure: ready=0, DEPTH+3 (=11) commits -> 8 queued (seq 0..7), drops=3, ovf=1;
//    then ready=1 -> seq 0..7 drain in order; next commit carries seq=11.
//  5 Full + simultaneous push/pop: FIFO full, ready=1 and commit same cycle -> no drop,
//    count stays 8, new record appears last.
//  6 TRACE_TIMESTAMP_EN: commits 4 cycles apart after reset release -> trace_cycle delta 4;
//    without the macro, trace_cycle=0 throughout. Also reset mid-drain -> valid=0 next cycle.

Source files
------------

// File: rtl/wb_commit_trace_pkg.sv
// Shared commit-record definitions for wb_commit_trace: field widths and packed record layout.
// The timestamp field only exists when TRACE_TIMESTAMP_EN is defined.
package wb_commit_trace_pkg;

  localparam int PC_W   = 32;
  localparam int RD_W   = 5;
  localparam int DATA_W = 32;
  localparam int SEQ_W  = 32;
  localparam int TS_W   = 32;
  localparam int DROP_W = 16;

  // Field order fixes the packing: pc in the MSBs, seq (or cycle) in the LSBs.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] wdata;
    logic [SEQ_W-1:0]  seq;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   cycle;
`endif
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/wb_commit_trace_if.sv
// Write-back commit inputs and trace-port handshake bundled for wb_commit_trace.
interface wb_commit_trace_if;
  import wb_commit_trace_pkg::*;

  logic              wb_have_inst;
  logic [PC_W-1:0]   wb_pc;
  logic              wb_rf_WE;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_wdata;

  logic              trace_valid;
  logic              trace_ready;
  logic [PC_W-1:0]   trace_pc;
  logic              trace_we;
  logic [RD_W-1:0]   trace_rd;
  logic [DATA_W-1:0] trace_wdata;
  logic [SEQ_W-1:0]  trace_seq;
  logic [TS_W-1:0]   trace_cycle;
  logic              trace_ovf;
  logic [DROP_W-1:0] trace_drops;

  modport slave (
    input  wb_have_inst, wb_pc, wb_rf_WE, wb_rd, wb_wdata, trace_ready,
    output trace_valid, trace_pc, trace_we, trace_rd, trace_wdata,
           trace_seq, trace_cycle, trace_ovf, trace_drops
  );

  modport master (
    output wb_have_inst, wb_pc, wb_rf_WE, wb_rd, wb_wdata, trace_ready,
    input  trace_valid, trace_pc, trace_we, trace_rd, trace_wdata,
           trace_seq, trace_cycle, trace_ovf, trace_drops
  );

endinterface

// File: rtl/wb_commit_trace_sync_fifo.sv
// Synchronous FIFO with a registered head word; occupancy tracked by a count, not pointer compare.
// Caller must never push while full unless it pops in the same cycle.
module trace_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;
  logic [AW-1:0]    w_rd_ptr_inc;

  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= w_rd_ptr_inc;

      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Head register tracks the entry that will sit at rd_ptr next cycle; an emptied FIFO keeps the old word.
      if (i_pop) begin
        if (r_count > (AW+1)'(1)) begin
          r_head <= r_mem[w_rd_ptr_inc];
        end else if (i_push) begin
          r_head <= i_din;
        end
      end else if (i_push && (r_count == '0)) begin
        r_head <= i_din;
      end
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/wb_commit_trace.sv
// Commit trace capture: builds one record per retiring instruction and queues it for a debug sink.
// Define TRACE_TIMESTAMP_EN to stamp each record with a free-running cycle counter.
module wb_commit_trace
  import wb_commit_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  wb_commit_trace_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       w_count;
  logic              w_full;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_we;
  trace_rec_t        w_rec_in;
  trace_rec_t        w_head;

  logic [SEQ_W-1:0]  r_seq_ctr;
  logic [DROP_W-1:0] r_drops;
  logic              r_ovf;

  assign w_valid = (w_count != '0);
  assign w_full  = (w_count == (AW+1)'(DEPTH));
  assign w_pop   = w_valid & bus.trace_ready;
  // A full FIFO still takes the new record when the head leaves in the same cycle.
  assign w_push  = bus.wb_have_inst & (~w_full | w_pop);
  assign w_we    = bus.wb_rf_WE & (bus.wb_rd != '0);

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_cycle_ctr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_ctr <= '0;
    end else begin
      r_cycle_ctr <= r_cycle_ctr + 1'b1;
    end
  end
`endif

  always_comb begin
    w_rec_in       = '0;
    w_rec_in.pc    = bus.wb_pc;
    w_rec_in.we    = w_we;
    w_rec_in.rd    = bus.wb_rd;
    w_rec_in.wdata = w_we ? bus.wb_wdata : '0;
    w_rec_in.seq   = r_seq_ctr;
`ifdef TRACE_TIMESTAMP_EN
    w_rec_in.cycle = r_cycle_ctr;
`endif
  end

  // Sequence numbers advance on every commit, stored or dropped, so gaps reveal losses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seq_ctr <= '0;
      r_drops   <= '0;
      r_ovf     <= 1'b0;
    end else if (bus.wb_have_inst) begin
      r_seq_ctr <= r_seq_ctr + 1'b1;
      if (!w_push) begin
        r_ovf <= 1'b1;
        if (r_drops != '1) begin
          r_drops <= r_drops + 1'b1;
        end
      end
    end
  end

  trace_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_rec_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.trace_valid = w_valid;
  assign bus.trace_pc    = w_head.pc;
  assign bus.trace_we    = w_head.we;
  assign bus.trace_rd    = w_head.rd;
  assign bus.trace_wdata = w_head.wdata;
  assign bus.trace_seq   = w_head.seq;
`ifdef TRACE_TIMESTAMP_EN
  assign bus.trace_cycle = w_head.cycle;
`else
  assign bus.trace_cycle = '0;
`endif
  assign bus.trace_ovf   = r_ovf;
  assign bus.trace_drops = r_drops;

endmodule

// File: tb/tb_wb_commit_trace.sv
// Scoreboard bench for wb_commit_trace: a queue-based reference model is updated from the
// committed stimulus, and a negedge monitor compares every visible head record and the status flags.
module tb_wb_commit_trace;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] seq;
    logic [31:0] cyc;
  } rec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   started;

  rec_t        mq[$];
  logic [31:0] m_seq;
  logic [31:0] m_cycle;
  int          m_drops;
  logic        m_ovf;
  rec_t        m_head;
  rec_t        m_new;

  wb_commit_trace_if bus ();

  wb_commit_trace #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model. State compared here reflects every clock edge already taken;
  // the current cycle's inputs are then folded into the model for the upcoming edge.
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      m_seq   = '0;
      m_cycle = '0;
      m_drops = 0;
      m_ovf   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      chk("valid", 32'(bus.trace_valid), 32'(mq.size() != 0));
      chk("ovf",   32'(bus.trace_ovf),   32'(m_ovf));
      chk("drops", 32'(bus.trace_drops), 32'(m_drops));
      if (mq.size() != 0) begin
        m_head = mq[0];
        chk("pc",    bus.trace_pc,           m_head.pc);
        chk("we",    32'(bus.trace_we),      32'(m_head.we));
        chk("rd",    32'(bus.trace_rd),      32'(m_head.rd));
        chk("wdata", bus.trace_wdata,        m_head.wdata);
        chk("seq",   bus.trace_seq,          m_head.seq);
`ifdef TRACE_TIMESTAMP_EN
        chk("cycle", bus.trace_cycle,        m_head.cyc);
`else
        chk("cycle", bus.trace_cycle,        32'h0);
`endif
        if (bus.trace_ready) begin
          $display("pop  seq=%0d pc=%08h we=%0b rd=%0d wdata=%08h cyc=%0d",
                   m_head.seq, m_head.pc, m_head.we, m_head.rd, m_head.wdata, m_head.cyc);
          void'(mq.pop_front());
        end
      end
      if (bus.wb_have_inst) begin
        m_new.pc    = bus.wb_pc;
        m_new.rd    = bus.wb_rd;
        m_new.we    = bus.wb_rf_WE && (bus.wb_rd != 5'd0);
        m_new.wdata = m_new.we ? bus.wb_wdata : 32'h0;
        m_new.seq   = m_seq;
        m_new.cyc   = m_cycle;
        m_seq       = m_seq + 1;
        if (mq.size() < DEPTH) begin
          mq.push_back(m_new);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
          $display("drop seq=%0d pc=%08h drops=%0d", m_new.seq, m_new.pc, m_drops);
        end
      end
      m_cycle = m_cycle + 1;
    end
  end

  task automatic step(input logic hi, input logic [31:0] pc, input logic we,
                      input logic [4:0] rd, input logic [31:0] wd, input logic rdy);
    bus.wb_have_inst = hi;
    bus.wb_pc        = pc;
    bus.wb_rf_WE     = we;
    bus.wb_rd        = rd;
    bus.wb_wdata     = wd;
    bus.trace_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    started = 1'b0;
    reset   = 1'b0;
    bus.wb_have_inst = 1'b0;
    bus.wb_pc        = '0;
    bus.wb_rf_WE     = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_wdata     = '0;
    bus.trace_ready  = 1'b0;

    // Reset held with commits present: nothing may be captured.
    for (int k = 0; k < 3; k++) step(1'b1, 32'h100 + k, 1'b1, 5'd3, 32'hABCD, 1'b1);
    reset = 1'b1;
    idle(2, 1'b1);

    // Single commit, then x0 write.
    step(1'b1, 32'h80, 1'b1, 5'd5, 32'h1234, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 32'h84, 1'b1, 5'd0, 32'hDEAD, 1'b1);
    idle(2, 1'b1);

    // Backpressure: DEPTH+3 commits, then drain, then one more commit.
    for (int k = 0; k < DEPTH + 3; k++)
      step(1'b1, 32'h1000 + 4*k, 1'b1, 5'(k + 1), 32'h5000 + k, 1'b0);
    idle(DEPTH + 2, 1'b1);
    step(1'b1, 32'h2000, 1'b1, 5'd7, 32'h77, 1'b1);
    idle(2, 1'b1);

    // Full FIFO with simultaneous pop and push.
    for (int k = 0; k < DEPTH; k++)
      step(1'b1, 32'h3000 + 4*k, 1'b0, 5'd9, 32'h9, 1'b0);
    step(1'b1, 32'h3FFC, 1'b1, 5'd31, 32'hCAFE, 1'b1);
    idle(2, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // Timestamp spacing after a fresh reset.
    reset = 1'b0;
    idle(1, 1'b1);
    reset = 1'b1;
    step(1'b1, 32'h4000, 1'b1, 5'd1, 32'h1, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 32'h4004, 1'b1, 5'd2, 32'h2, 1'b1);
    idle(2, 1'b1);

    // Reset in the middle of a drain.
    for (int k = 0; k < 5; k++) step(1'b1, 32'h5000 + 4*k, 1'b1, 5'd4, 32'h44, 1'b0);
    idle(2, 1'b1);
    reset = 1'b0;
    step(1'b1, 32'h5100, 1'b1, 5'd4, 32'h44, 1'b1);
    reset = 1'b1;
    idle(3, 1'b1);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 2500; k++) begin
      reset = ($urandom_range(0, 399) != 0);
      step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom, $urandom_range(0, 9) < 5);
    end
    reset = 1'b1;
    idle(DEPTH + 4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
